// File: rtl/lsu_addr_gen_if.sv
// Handshake and bus bundle for the LSU streaming address generator.
// slave  : the view used by lsu_addr_gen itself.
// master : the view used by whatever issues descriptors and consumes addresses.
// Optional 2D descriptor fields are present only when LSU_AGEN_2D_EN is defined.
interface lsu_addr_gen_if #(
    parameter int A_W   = 10,
    parameter int LEN_W = 10
);
    localparam int GA_W = A_W + 3;

    // Descriptor channel
    logic             cfg_valid;
    logic             cfg_ready;
    logic [GA_W-1:0]  cfg_base;
    logic [GA_W-1:0]  cfg_stride;
    logic [LEN_W-1:0] cfg_len;
`ifdef LSU_AGEN_2D_EN
    logic [LEN_W-1:0] cfg_len_outer;
    logic [GA_W-1:0]  cfg_stride_outer;
`endif
    logic             abort;

    // Address channel towards the crossbar
    logic [GA_W-1:0]  LSU_addr_bus;
    logic             addr_valid;
    logic             addr_ready;

    // Status
    logic             busy;
    logic             done;

    modport slave (
`ifdef LSU_AGEN_2D_EN
        input  cfg_len_outer, cfg_stride_outer,
`endif
        input  cfg_valid, cfg_base, cfg_stride, cfg_len, abort, addr_ready,
        output cfg_ready, LSU_addr_bus, addr_valid, busy, done
    );

    modport master (
`ifdef LSU_AGEN_2D_EN
        output cfg_len_outer, cfg_stride_outer,
`endif
        output cfg_valid, cfg_base, cfg_stride, cfg_len, abort, addr_ready,
        input  cfg_ready, LSU_addr_bus, addr_valid, busy, done
    );
endinterface

// File: rtl/lsu_addr_gen.sv
// Per-LSU streaming address generator feeding one LSU_addr_bus input of the
// 8x8 address crossbar. A {base, stride, length} descriptor becomes a stream
// of global word addresses, each presented as {bank_sel, row} with low-order
// bank interleave (bank_sel = g[2:0], row = g[GA_W-1:3]).
// Optional feature macro: LSU_AGEN_2D_EN adds an outer loop
// (cfg_len_outer inner runs, row base advanced by cfg_stride_outer).
module lsu_addr_gen #(
    parameter int A_W   = 10,
    parameter int LEN_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    lsu_addr_gen_if.slave  bus_if
);
    localparam int GA_W = A_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [GA_W-1:0]  cur_q, cur_d;        // global address currently on the bus
    logic [GA_W-1:0]  stride_q, stride_d;
    logic [LEN_W-1:0] rem_q, rem_d;        // addresses left in the current run
    logic [GA_W-1:0]  bus_q, bus_d;        // mapped address driven to the crossbar
`ifdef LSU_AGEN_2D_EN
    logic [GA_W-1:0]  row_base_q, row_base_d;
    logic [GA_W-1:0]  stride_outer_q, stride_outer_d;
    logic [LEN_W-1:0] len_inner_q, len_inner_d;
    logic [LEN_W-1:0] rem_outer_q, rem_outer_d;
    logic [GA_W-1:0]  next_row;
`endif

    logic [GA_W-1:0]  next_addr;
    logic             len_zero;

    // Global address -> {bank_sel, row}; consecutive words land in consecutive banks.
    function automatic logic [GA_W-1:0] map_addr(input logic [GA_W-1:0] g);
        return {g[2:0], g[GA_W-1:3]};
    endfunction

    // Stride addition wraps silently modulo 2^GA_W.
    assign next_addr = cur_q + stride_q;
`ifdef LSU_AGEN_2D_EN
    assign next_row  = row_base_q + stride_outer_q;
    assign len_zero  = (bus_if.cfg_len == '0) || (bus_if.cfg_len_outer == '0);
`else
    assign len_zero  = (bus_if.cfg_len == '0);
`endif

    // Status outputs decode straight from the state register so reset reaches them immediately.
    assign bus_if.cfg_ready    = (state_q == IDLE);
    assign bus_if.addr_valid   = (state_q == RUN);
    assign bus_if.busy         = (state_q != IDLE);
    assign bus_if.done         = (state_q == DONE);
    assign bus_if.LSU_addr_bus = bus_q;

    // Next-state and datapath update for the IDLE -> RUN -> DONE stream sequencer.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no branch of the case infers a latch.
        state_d  = state_q;
        cur_d    = cur_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        bus_d    = bus_q;
`ifdef LSU_AGEN_2D_EN
        row_base_d     = row_base_q;
        stride_outer_d = stride_outer_q;
        len_inner_d    = len_inner_q;
        rem_outer_d    = rem_outer_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus_if.cfg_valid) begin
                    cur_d    = bus_if.cfg_base;
                    stride_d = bus_if.cfg_stride;
                    rem_d    = bus_if.cfg_len;
`ifdef LSU_AGEN_2D_EN
                    row_base_d     = bus_if.cfg_base;
                    stride_outer_d = bus_if.cfg_stride_outer;
                    len_inner_d    = bus_if.cfg_len;
                    rem_outer_d    = bus_if.cfg_len_outer;
`endif
                    if (len_zero) begin
                        // Empty stream: the bus keeps its previous value.
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        bus_d   = map_addr(bus_if.cfg_base);
                    end
                end
            end
            RUN: begin
                if (bus_if.abort) begin
                    // A coincident handshake still counts downstream; nothing further is issued.
                    state_d = IDLE;
                end else if (bus_if.addr_ready) begin
                    if (rem_q == LEN_W'(1)) begin
`ifdef LSU_AGEN_2D_EN
                        if (rem_outer_q == LEN_W'(1)) begin
                            state_d     = DONE;
                            rem_d       = '0;
                            rem_outer_d = '0;
                        end else begin
                            // Jump to the next row without a bubble.
                            row_base_d  = next_row;
                            cur_d       = next_row;
                            bus_d       = map_addr(next_row);
                            rem_d       = len_inner_q;
                            rem_outer_d = rem_outer_q - LEN_W'(1);
                        end
`else
                        state_d = DONE;
                        rem_d   = '0;
                        cur_d   = next_addr;
`endif
                    end else begin
                        cur_d = next_addr;
                        rem_d = rem_q - LEN_W'(1);
                        bus_d = map_addr(next_addr);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            bus_q    <= '0;
`ifdef LSU_AGEN_2D_EN
            row_base_q     <= '0;
            stride_outer_q <= '0;
            len_inner_q    <= '0;
            rem_outer_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cur_q    <= cur_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            bus_q    <= bus_d;
`ifdef LSU_AGEN_2D_EN
            row_base_q     <= row_base_d;
            stride_outer_q <= stride_outer_d;
            len_inner_q    <= len_inner_d;
            rem_outer_q    <= rem_outer_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_addr_gen.sv
// Scoreboard bench for lsu_addr_gen: the stimulus process pushes the expected
// address stream computed from plain modular arithmetic; a monitor on the
// falling edge pops and compares on every accepted address and checks the
// done pulse timing.
`timescale 1ns/1ps
module tb_lsu_addr_gen;
    localparam int A_W   = 10;
    localparam int LEN_W = 10;
    localparam int GA_W  = A_W + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_addr_gen_if #(.A_W(A_W), .LEN_W(LEN_W)) agen_if ();

    lsu_addr_gen #(.A_W(A_W), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (agen_if)
    );

    typedef struct {
        logic [GA_W-1:0] bus;
        bit              last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_due = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: address idx of a stream is base + idx*stride modulo 2^GA_W,
    // stride read as two's complement; the bus carries bank (g mod 8) above row (g div 8).
    function automatic logic [GA_W-1:0] model_bus(input logic [GA_W-1:0] base,
                                                  input logic [GA_W-1:0] stride,
                                                  input int idx);
        int span;
        int s;
        int g;
        span = 1 << GA_W;
        s = (int'(stride) >= span / 2) ? int'(stride) - span : int'(stride);
        g = (int'(base) + idx * s) % span;
        if (g < 0) g += span;
        return GA_W'((g % 8) * (1 << A_W) + g / 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares accepted addresses against the scoreboard and checks done timing.
    always @(negedge clk) begin
        if (rst) begin
            done_due = -1;
        end else begin
            cyc++;
            check("done_pulse", 32'(agen_if.done), 32'(done_due == cyc));
            check("busy_vs_cfg_ready", 32'(agen_if.busy), 32'(!agen_if.cfg_ready));
            if (agen_if.addr_valid && agen_if.addr_ready) begin
                if (exp_q.size() == 0) begin
                    check("addr_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("addr_bus", 32'(agen_if.LSU_addr_bus), 32'(e.bus));
                    if (e.last && !agen_if.abort) done_due = cyc + 1;
                end
            end
            if (agen_if.cfg_valid && agen_if.cfg_ready && agen_if.cfg_len == '0)
                done_due = cyc + 1;
        end
    end

    // One descriptor end to end. ready_pct: chance addr_ready is high per cycle;
    // stall_first: cycles addr_ready is held low at the first address;
    // abort_after: abort once this many addresses were accepted (-1 = never).
    task automatic run_stream(input logic [GA_W-1:0] base, input logic [GA_W-1:0] stride,
                              input int len, input int ready_pct, input int stall_first,
                              input int abort_after);
        int              budget;
        int              acc;
        int              stall;
        bit              rdy;
        bit              abort_now;
        logic [GA_W-1:0] pbus;
        bit              pvalid;
        budget = 0;
        acc    = 0;
        stall  = stall_first;
        while (!agen_if.cfg_ready && budget < 20) begin
            tick();
            budget++;
        end
        check("cfg_ready_wait", 32'(agen_if.cfg_ready), 32'd1);

        for (int i = 0; i < len; i++)
            exp_q.push_back('{bus: model_bus(base, stride, i), last: (i == len - 1)});

        agen_if.cfg_valid  = 1'b1;
        agen_if.cfg_base   = base;
        agen_if.cfg_stride = stride;
        agen_if.cfg_len    = LEN_W'(len);
        tick();
        agen_if.cfg_valid  = 1'b0;
        agen_if.cfg_base   = GA_W'($urandom);
        agen_if.cfg_stride = GA_W'($urandom);
        agen_if.cfg_len    = LEN_W'($urandom);

        // First address one cycle after the descriptor handshake.
        if (len != 0) begin
            check("first_valid", 32'(agen_if.addr_valid), 32'd1);
            check("first_addr", 32'(agen_if.LSU_addr_bus), 32'(model_bus(base, stride, 0)));
        end else begin
            check("zero_len_no_valid", 32'(agen_if.addr_valid), 32'd0);
        end

        for (int c = 0; c < 300 && agen_if.busy; c++) begin
            if (stall > 0 && agen_if.addr_valid) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            abort_now          = (abort_after >= 0) && (acc == abort_after) && agen_if.addr_valid;
            agen_if.addr_ready = rdy;
            agen_if.abort      = abort_now;
            if (agen_if.addr_valid && rdy) acc++;
            pbus   = agen_if.LSU_addr_bus;
            pvalid = agen_if.addr_valid;
            tick();
            agen_if.abort = 1'b0;
            if (abort_now) begin
                exp_q.delete();
                check("abort_valid", 32'(agen_if.addr_valid), 32'd0);
                check("abort_cfg_ready", 32'(agen_if.cfg_ready), 32'd1);
                check("abort_busy", 32'(agen_if.busy), 32'd0);
            end else if (pvalid && !rdy) begin
                check("hold_valid", 32'(agen_if.addr_valid), 32'd1);
                check("hold_bus", 32'(agen_if.LSU_addr_bus), 32'(pbus));
            end
        end
        check("stream_end_idle", 32'(agen_if.busy), 32'd0);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int sel;
        logic [GA_W-1:0] base;
        logic [GA_W-1:0] stride;

        rst                = 1'b1;
        agen_if.cfg_valid  = 1'b0;
        agen_if.cfg_base   = '0;
        agen_if.cfg_stride = '0;
        agen_if.cfg_len    = '0;
        agen_if.abort      = 1'b0;
        agen_if.addr_ready = 1'b0;
`ifdef LSU_AGEN_2D_EN
        agen_if.cfg_len_outer    = LEN_W'(1);
        agen_if.cfg_stride_outer = '0;
`endif
        #1;
        check("rst_cfg_ready", 32'(agen_if.cfg_ready), 32'd1);
        check("rst_addr_valid", 32'(agen_if.addr_valid), 32'd0);
        check("rst_busy", 32'(agen_if.busy), 32'd0);
        check("rst_done", 32'(agen_if.done), 32'd0);
        check("rst_bus", 32'(agen_if.LSU_addr_bus), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed cases
        run_stream(13'h0005, 13'h0001, 4, 100, 0, -1);   // 0x1400 0x1800 0x1C00 0x0001
        run_stream(13'h1FFF, 13'h0001, 2, 100, 0, -1);   // wrap: 0x1FFF 0x0000
        run_stream(13'h0010, 13'h1FF8, 3, 100, 0, -1);   // -8: 0x0002 0x0001 0x0000
        run_stream(13'h0003, 13'h0008, 2, 100, 3, -1);   // hold 0x0C00, then 0x0C01
        run_stream(13'h0123, 13'h0005, 0, 100, 0, -1);   // empty stream
        run_stream(13'h0040, 13'h0001, 8, 100, 0, 2);    // abort after two acceptances

        // Reset asserted mid-stream acts without a clock edge.
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{bus: model_bus(13'h0777, 13'h0003, i), last: (i == 7)});
        agen_if.addr_ready = 1'b0;
        agen_if.cfg_valid  = 1'b1;
        agen_if.cfg_base   = 13'h0777;
        agen_if.cfg_stride = 13'h0003;
        agen_if.cfg_len    = LEN_W'(8);
        tick();
        agen_if.cfg_valid = 1'b0;
        tick();
        check("pre_reset_valid", 32'(agen_if.addr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_addr_valid", 32'(agen_if.addr_valid), 32'd0);
        check("midrst_bus", 32'(agen_if.LSU_addr_bus), 32'd0);
        check("midrst_cfg_ready", 32'(agen_if.cfg_ready), 32'd1);
        check("midrst_busy", 32'(agen_if.busy), 32'd0);
        check("midrst_done", 32'(agen_if.done), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Randomized descriptors
        for (int n = 0; n < 60; n++) begin
            base = GA_W'($urandom);
            sel  = $urandom_range(3);
            case (sel)
                0:       stride = GA_W'($urandom_range(1, 8));
                1:       stride = GA_W'(-$urandom_range(1, 8));
                2:       stride = GA_W'($urandom);
                default: stride = '0;
            endcase
            len = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 12);
            run_stream(base, stride, len, $urandom_range(40, 100), $urandom_range(3),
                       (len > 0 && $urandom_range(6) == 0) ? $urandom_range(len - 1) : -1);
        end

        tick();
        tick();
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
